// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, CTRL/STATUS field positions, line states
// and the CTRL reset value. Used by the RX controller and the TX controller.
package uart_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_BAUD   = 2'd1;
  localparam logic [1:0] ADDR_DATA   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_CFG_MSB   = 7;
  localparam int CTRL_IERX_BIT  = 8;
  localparam int CTRL_IEERR_BIT = 9;

  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_OVR_BIT   = 2;
  localparam int ST_BUSY_BIT  = 3;
  localparam int ST_PEND_BIT  = 4;
  localparam int ST_COUNT_LSB = 8;

  localparam logic [15:0] CTRL_RESET = 16'h0003;

  typedef enum logic {
    LINE_IDLE = 1'b0,
    LINE_BUSY = 1'b1
  } line_state_e;

  // Bit order matches CTRL[7:0] so a register write can be cast straight in.
  typedef struct packed {
    logic       rx_en;
    logic [1:0] parity;
    logic [1:0] sbit;
    logic [2:0] dbit;
  } rx_cfg_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO; a push into a full FIFO succeeds only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver front-end: baud tick, staged configuration applied on an idle line,
// character capture into the RX FIFO, register port and interrupt.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int          DEPTH      = 16,
  parameter logic [15:0] DIV_RESET  = 16'd27,
  parameter int          WDOG_TICKS = 208
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [1:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq,
  input  logic        rx_i,
  output logic        s_tick,
  output logic [2:0]  dbit_select_o,
  output logic [1:0]  sbit_select_o,
  output logic [1:0]  parity_select_o,
  input  logic        rx_done_tick_i,
  input  logic [7:0]  rx_dout_i,
  input  logic        parity_error_i,
  input  logic        frame_error_i
);

  localparam int             CW        = $clog2(DEPTH) + 1;
  localparam int             WDW       = $clog2(WDOG_TICKS + 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_TICKS - 1);

  rx_cfg_t        stage_q, stage_d, act_q, act_d;
  logic           ie_rx_q, ie_rx_d, ie_err_q, ie_err_d;
  logic [15:0]    baud_stage_q, baud_stage_d, div_q, div_d, cnt_q, cnt_d;
  logic           cfg_pending_q, cfg_pending_d;
  line_state_e    state_q, state_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           cap_valid_q, cap_valid_d, cap_frame_q, cap_frame_d;
  logic [7:0]     cap_data_q, cap_data_d;
  logic           overrun_q, overrun_d;
  logic [15:0]    rdata_q, rdata_d;

  logic           wr_cfg, apply, ovr_clr, fifo_pop;
  logic [15:0]    status_word;
  logic [9:0]     fifo_rdata;
  logic           fifo_full, fifo_empty, fifo_drop;
  logic [CW-1:0]  fifo_count;

  assign s_tick          = (div_q != 16'd0) && (cnt_q == div_q - 16'd1);
  assign fifo_pop        = rd_en && (addr == ADDR_DATA);
  assign irq             = (ie_rx_q & ~fifo_empty) | (ie_err_q & overrun_q);
  assign rdata           = rdata_q;
  assign dbit_select_o   = act_q.dbit;
  assign sbit_select_o   = act_q.sbit;
  assign parity_select_o = act_q.parity;

  uart_rx_fifo #(.WIDTH(10), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cap_valid_q),
    .wdata   ({cap_frame_q, parity_error_i, cap_data_q}),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .drop    (fifo_drop),
    .count   (fifo_count)
  );

  always_comb begin
    status_word = '0;
    status_word[ST_EMPTY_BIT] = fifo_empty;
    status_word[ST_FULL_BIT]  = fifo_full;
    status_word[ST_OVR_BIT]   = overrun_q;
    status_word[ST_BUSY_BIT]  = (state_q == LINE_BUSY);
    status_word[ST_PEND_BIT]  = cfg_pending_q;
    status_word[ST_COUNT_LSB +: 8] = 8'(fifo_count);
  end

  always_comb begin
    stage_d      = stage_q;
    act_d        = act_q;
    ie_rx_d      = ie_rx_q;
    ie_err_d     = ie_err_q;
    baud_stage_d = baud_stage_q;
    div_d        = div_q;
    state_d      = state_q;
    wdog_d       = wdog_q;
    wr_cfg       = 1'b0;
    apply        = 1'b0;
    ovr_clr      = 1'b0;

    if (wr_en) begin
      case (addr)
        ADDR_CTRL: begin
          stage_d  = rx_cfg_t'(wdata[CTRL_CFG_MSB:0]);
          ie_rx_d  = wdata[CTRL_IERX_BIT];
          ie_err_d = wdata[CTRL_IEERR_BIT];
          wr_cfg   = 1'b1;
        end
        ADDR_BAUD: begin
          baud_stage_d = wdata;
          wr_cfg       = 1'b1;
        end
        ADDR_STATUS: ovr_clr = wdata[ST_OVR_BIT];
        default: ;
      endcase
    end

    // A start bit always wins over a pending apply; the apply waits for the next idle line.
    case (state_q)
      LINE_IDLE: begin
        if (!rx_i) begin
          state_d = LINE_BUSY;
          wdog_d  = '0;
        end else if (cfg_pending_q) begin
          apply = 1'b1;
        end
      end
      default: begin
        if (rx_done_tick_i) begin
          state_d = LINE_IDLE;
        end else if (s_tick) begin
          if (wdog_q == WDOG_LAST) state_d = LINE_IDLE;
          else                     wdog_d  = wdog_q + 1'b1;
        end
      end
    endcase

    if (apply) begin
      act_d = stage_q;
      div_d = baud_stage_q;
    end
    cfg_pending_d = wr_cfg | (cfg_pending_q & ~apply);

    if (apply || div_q == 16'd0 || s_tick) cnt_d = '0;
    else                                   cnt_d = cnt_q + 16'd1;

    cap_valid_d = rx_done_tick_i & act_q.rx_en;
    cap_data_d  = cap_valid_d ? rx_dout_i     : cap_data_q;
    cap_frame_d = cap_valid_d ? frame_error_i : cap_frame_q;

    overrun_d = (overrun_q & ~ovr_clr) | fifo_drop;

    rdata_d = rdata_q;
    if (rd_en) begin
      case (addr)
        ADDR_CTRL:   rdata_d = {6'b0, ie_err_q, ie_rx_q, stage_q};
        ADDR_BAUD:   rdata_d = baud_stage_q;
        ADDR_DATA:   rdata_d = fifo_empty ? 16'h0000 : {1'b1, 5'b0, fifo_rdata};
        default:     rdata_d = status_word;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q       <= rx_cfg_t'(CTRL_RESET[CTRL_CFG_MSB:0]);
      act_q         <= rx_cfg_t'(CTRL_RESET[CTRL_CFG_MSB:0]);
      ie_rx_q       <= CTRL_RESET[CTRL_IERX_BIT];
      ie_err_q      <= CTRL_RESET[CTRL_IEERR_BIT];
      baud_stage_q  <= DIV_RESET;
      div_q         <= DIV_RESET;
      cnt_q         <= '0;
      cfg_pending_q <= 1'b0;
      state_q       <= LINE_IDLE;
      wdog_q        <= '0;
      cap_valid_q   <= 1'b0;
      cap_data_q    <= '0;
      cap_frame_q   <= 1'b0;
      overrun_q     <= 1'b0;
      rdata_q       <= '0;
    end else begin
      stage_q       <= stage_d;
      act_q         <= act_d;
      ie_rx_q       <= ie_rx_d;
      ie_err_q      <= ie_err_d;
      baud_stage_q  <= baud_stage_d;
      div_q         <= div_d;
      cnt_q         <= cnt_d;
      cfg_pending_q <= cfg_pending_d;
      state_q       <= state_d;
      wdog_q        <= wdog_d;
      cap_valid_q   <= cap_valid_d;
      cap_data_q    <= cap_data_d;
      cap_frame_q   <= cap_frame_d;
      overrun_q     <= overrun_d;
      rdata_q       <= rdata_d;
    end
  end

endmodule
